// File: rtl/down_count_monitor.sv
// -----------------------------------------------------------------------------
// down_count_monitor
//
// Synchronous consumer for a 4-bit asynchronous ripple down-counter.
//
// The raw counter bus is brought into the clk domain through a two-flop
// synchronizer. A value is accepted only after it has been stable for
// STABLE_CYCLES consecutive synchronized samples, which filters out ripple
// transients. Accepted values drive a clean count, a wrap pulse on 0 -> 15,
// a wrap counter and a sticky missed-step flag.
//
// Parameters:
//   STABLE_CYCLES  identical synchronized samples needed to accept (1..15)
//   EXT_W          width of the wrap counter
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous active-low reset
//   cnt_in    in   [3:0] raw ripple counter output (asynchronous to clk)
//   clr       in   synchronous clear of ext_cnt and skip_err
//   cnt_q     out  [3:0] last accepted count
//   valid     out  one-cycle pulse: cnt_q took a new value on the last edge
//   wrap      out  one-cycle pulse with valid when the accepted step is 0 -> 15
//   ext_cnt   out  [EXT_W-1:0] number of wraps, modulo 2^EXT_W
//   skip_err  out  sticky: an accepted step was not old-1 mod 16
//   zero      out  level, high while cnt_q == 0
//
// Handshake: valid is a producer-only strobe with no ready. The consumer must
// sample cnt_q, wrap and ext_cnt in the cycle valid is high; there is no
// backpressure and nothing is held for a late consumer.
// -----------------------------------------------------------------------------
module down_count_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int EXT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             clr,
    output logic [3:0]       cnt_q,
    output logic             valid,
    output logic             wrap,
    output logic [EXT_W-1:0] ext_cnt,
    output logic             skip_err,
    output logic             zero
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    // Synchronizer stages. s1 may go metastable; only s2 is used downstream.
    logic [3:0] s1;
    logic [3:0] s2;

    // Stability filter: current candidate and how long it has been seen.
    logic [3:0] cand;
    logic [3:0] run;

    // Decisions taken from registered state only.
    logic       accept;
    logic       wrap_cond;
    logic       skip_cond;
    logic [3:0] expect_next;

    always_comb begin
        accept      = 1'b0;
        wrap_cond   = 1'b0;
        skip_cond   = 1'b0;
        expect_next = cnt_q - 4'd1;
        // A candidate that equals the current count is a return to an
        // already-accepted value and must not generate a new valid.
        accept      = (run == RUN_MAX) && (cand != cnt_q);
        wrap_cond   = (cnt_q == 4'd0) && (cand == 4'd15);
        skip_cond   = (cand != expect_next);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 4'd0;
            s2       <= 4'd0;
            cand     <= 4'd0;
            // Starting saturated with cand == cnt_q == 0 matches the source
            // counter's own reset value, so nothing is accepted until the
            // synchronized input actually moves.
            run      <= RUN_MAX;
            cnt_q    <= 4'd0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            ext_cnt  <= '0;
            skip_err <= 1'b0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;

            // Any change of the synchronized value restarts the window.
            if (s2 != cand) begin
                cand <= s2;
                run  <= 4'd1;
            end else if (run != RUN_MAX) begin
                run <= run + 4'd1;
            end

            valid <= accept;
            wrap  <= accept && wrap_cond;

            if (accept) begin
                cnt_q <= cand;
            end

            // clr dominates the wrap counter even on a coincident wrap.
            if (clr) begin
                ext_cnt <= '0;
            end else if (accept && wrap_cond) begin
                ext_cnt <= ext_cnt + EXT_W'(1);
            end

            // A new skip dominates clr so an error is never silently lost.
            if (accept && skip_cond) begin
                skip_err <= 1'b1;
            end else if (clr) begin
                skip_err <= 1'b0;
            end
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: tb/tb_down_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_down_count_monitor
//
// Directed bench for down_count_monitor. Two instances share the stimulus:
// one with default parameters and one with a 2-bit wrap counter for the
// rollover case. Each accepted step is predicted by a small model and pushed
// to an expected queue; the monitor pops it when valid appears.
// -----------------------------------------------------------------------------
module tb_down_count_monitor;

    localparam int W = 16;  // {cnt, wrap, skip, ext[7:0], ext2[1:0]}

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       clr;

    logic [3:0] cnt_q;
    logic       valid;
    logic       wrap;
    logic [7:0] ext_cnt;
    logic       skip_err;
    logic       zero;

    logic [3:0] w2_cnt_q;
    logic       w2_valid;
    logic       w2_wrap;
    logic [1:0] w2_ext_cnt;
    logic       w2_skip_err;
    logic       w2_zero;

    int vectors = 0;
    int fails   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state.
    logic [3:0] m_cnt;
    logic [7:0] m_ext;
    logic       m_skip;

    down_count_monitor #(.STABLE_CYCLES(2), .EXT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .clr      (clr),
        .cnt_q    (cnt_q),
        .valid    (valid),
        .wrap     (wrap),
        .ext_cnt  (ext_cnt),
        .skip_err (skip_err),
        .zero     (zero)
    );

    down_count_monitor #(.STABLE_CYCLES(2), .EXT_W(2)) dut_w2 (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .clr      (clr),
        .cnt_q    (w2_cnt_q),
        .valid    (w2_valid),
        .wrap     (w2_wrap),
        .ext_cnt  (w2_ext_cnt),
        .skip_err (w2_skip_err),
        .zero     (w2_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        if (rst === 1'b1 && valid === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("FAIL sb_unexpected_valid got cnt_q=%0d expected no valid", cnt_q);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                obs_v = {cnt_q, wrap, skip_err, ext_cnt, w2_ext_cnt};
                vectors++;
                assert (obs_v === exp_v)
                else begin
                    fails++;
                    $error("FAIL sb_accept got {cnt,wrap,skip,ext,ext2}=%h expected %h", obs_v, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive a value held for `hold` clocks (starting just after a falling
    // edge). If it differs from the model count, predict the accept and
    // check that valid rises exactly on the fifth rising edge.
    task automatic step(input logic [3:0] v, input int hold, input bit clr_acc);
        bit         acc;
        logic       w;
        logic       sk;
        logic [3:0] prev_m1;
        acc = (v != m_cnt);
        if (acc) begin
            prev_m1 = m_cnt - 4'd1;
            w  = (m_cnt == 4'd0) && (v == 4'd15);
            sk = (v != prev_m1);
            if (clr_acc)  m_ext = 8'd0;
            else if (w)   m_ext = m_ext + 8'd1;
            if (sk)            m_skip = 1'b1;
            else if (clr_acc)  m_skip = 1'b0;
            m_cnt = v;
            exp_q.push_back({v, w, m_skip, m_ext, m_ext[1:0]});
        end
        cnt_in = v;
        for (int i = 0; i < hold; i++) begin
            clr = clr_acc && (i == 4);
            @(negedge clk);
            vectors++;
            assert (valid === (acc && i == 4))
            else begin
                fails++;
                $error("FAIL valid_timing value=%0d cycle=%0d got %b expected %b",
                       v, i, valid, (acc && i == 4));
            end
        end
        clr = 1'b0;
    endtask

    task automatic hold_reset(input logic [3:0] v, input int cycles);
        rst    = 1'b0;
        cnt_in = v;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_cnt_q", 8'(cnt_q), 8'd0);
            check("rst_zero", 8'(zero), 8'd1);
            check("rst_valid", 8'(valid), 8'd0);
            check("rst_ext", ext_cnt, 8'd0);
            check("rst_skip", 8'(skip_err), 8'd0);
        end
        rst    = 1'b1;
        m_cnt  = 4'd0;
        m_ext  = 8'd0;
        m_skip = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        m_ext  = 8'd0;
        m_skip = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0] roll_exp[5];
        logic [3:0] cnt_before;
        roll_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst    = 1'b0;
        cnt_in = 4'd9;
        clr    = 1'b0;
        m_cnt  = 4'd0;
        m_ext  = 8'd0;
        m_skip = 1'b0;

        // Reset with 9 on the input, then 9 is accepted as a skip.
        hold_reset(4'd9, 3);
        step(4'd9, 8, 1'b0);
        check("reset_accept_skip", 8'(skip_err), 8'd1);

        // Reset mid-window discards the pending candidate.
        cnt_in = 4'd8;
        @(negedge clk);
        @(negedge clk);
        hold_reset(4'd0, 2);
        step(4'd0, 8, 1'b0);
        check("mid_reset_cnt_q", 8'(cnt_q), 8'd0);

        // Normal down-count 0 -> 15 -> ... -> 0 -> 15.
        for (int k = 15; k >= 0; k--) step(4'(k), 8, 1'b0);
        step(4'd15, 8, 1'b0);
        check("count_ext", ext_cnt, 8'd2);
        check("count_skip", 8'(skip_err), 8'd0);

        // Walk down to 6, then a one-clock glitch of 4 before 5.
        for (int k = 14; k >= 6; k--) step(4'(k), 8, 1'b0);
        check("zero_low", 8'(zero), 8'd0);
        cnt_in = 4'd4;
        @(negedge clk);
        step(4'd5, 8, 1'b0);
        check("glitch_cnt_q", 8'(cnt_q), 8'd5);
        check("glitch_skip", 8'(skip_err), 8'd0);

        // Down to 10 (one more wrap on the way), then miss a step to 8.
        for (int k = 4; k >= 0; k--) step(4'(k), 8, 1'b0);
        check("zero_high", 8'(zero), 8'd1);
        for (int k = 15; k >= 10; k--) step(4'(k), 8, 1'b0);
        step(4'd8, 8, 1'b0);
        step(4'd7, 8, 1'b0);
        check("skip_sticky", 8'(skip_err), 8'd1);
        cnt_before = cnt_q;
        clr_pulse();
        check("clr_skip", 8'(skip_err), 8'd0);
        check("clr_ext", ext_cnt, 8'd0);
        check("clr_cnt_q", 8'(cnt_q), 8'd7);
        check("clr_cnt_q_held", 8'(cnt_q), 8'(cnt_before));

        // Build ext_cnt = 3, then clr exactly on a wrap accept.
        for (int k = 6; k >= 0; k--) step(4'(k), 8, 1'b0);
        step(4'd15, 8, 1'b0);
        step(4'd0, 8, 1'b0);
        step(4'd15, 8, 1'b0);
        step(4'd0, 8, 1'b0);
        step(4'd15, 8, 1'b0);
        check("pre_clr_ext", ext_cnt, 8'd3);
        step(4'd0, 8, 1'b0);
        step(4'd15, 8, 1'b1);
        check("clr_wrap_ext", ext_cnt, 8'd0);

        // Rollover of the 2-bit wrap counter over five wraps.
        for (int r = 0; r < 5; r++) begin
            step(4'd0, 8, 1'b0);
            step(4'd15, 8, 1'b0);
            check("rollover_ext2", 8'(w2_ext_cnt), 8'(roll_exp[r]));
        end
        check("rollover_ext8", ext_cnt, 8'd5);

        vectors++;
        assert (exp_q.size() == 0)
        else begin
            fails++;
            $error("FAIL sb_drain got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
